// File: rtl/adc_interface_par12_pkg.sv
// Shared definitions for the 12-bit parallel ADC interface.
// Holds the controller state encoding, host op-code bit positions,
// default timing constants and the cycle-counter type.
package adc_interface_par12_pkg;

    // Host op-code bit positions
    localparam int unsigned OP_RST  = 0;
    localparam int unsigned OP_CONV = 1;

    // Default timing, in clk cycles
    localparam int unsigned DEF_T_CONVST  = 2;
    localparam int unsigned DEF_T_RD      = 3;
    localparam int unsigned DEF_T_TIMEOUT = 200;

    // Extra cycles granted in S_WAIT for BUSY to show up before the
    // controller assumes the conversion finished without a BUSY pulse
    localparam int unsigned BUSY_GRACE = 4;

    // Cycle counter; every timing parameter must fit (<= 255)
    localparam int unsigned CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_SETUP,
        S_CONV,
        S_WAIT,
        S_READ
    } state_t;

    // Registered host command
    typedef struct packed {
        logic       start;
        logic       srst;
        logic [1:0] chan;
    } cmd_t;

    // Counter value seen on the last cycle of an N-cycle interval
    function automatic cnt_t last_cnt(input int unsigned cycles);
        return cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/adc_interface_par12_if.sv
// Bundle of host command/status signals and ADC pins.
//   host : cs, op[3:0], addr[7:0] in; rdy, data_out[15:0], valid, err out
//   ADC  : AD[1:0], CONVST, CS, RD out (active-low strobes); BUSY, DB[11:0] in
// slave  = the interface controller, master = host + ADC side.
interface adc_interface_par12_if;

    logic        cs;
    logic [3:0]  op;
    logic [7:0]  addr;
    logic        rdy;
    logic [15:0] data_out;
    logic        valid;
    logic        err;

    logic [1:0]  AD;
    logic        CONVST;
    logic        BUSY;
    logic        CS;
    logic        RD;
    logic [11:0] DB;

    modport master (
        output cs, op, addr, BUSY, DB,
        input  rdy, data_out, valid, err, AD, CONVST, CS, RD
    );

    modport slave (
        input  cs, op, addr, BUSY, DB,
        output rdy, data_out, valid, err, AD, CONVST, CS, RD
    );

endinterface

// File: rtl/adc_interface_par12_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : asynchronous active-high reset, output forced low
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/adc_interface_par12.sv
// Controller for a 12-bit parallel-output ADC.
// A host start command selects a channel, pulses CONVST low, waits for
// BUSY to fall (or times out), then reads DB with CS/RD low and presents
// the sample on data_out with a one-cycle valid pulse.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of adc_interface_par12_if (host + ADC pins)
// Parameters: T_CONVST (CONVST low width), T_RD (CS/RD low width),
// T_TIMEOUT (max cycles from CONVST rise to BUSY fall); all <= 255.
module adc_interface_par12
    import adc_interface_par12_pkg::*;
#(
    parameter int unsigned T_CONVST  = DEF_T_CONVST,
    parameter int unsigned T_RD      = DEF_T_RD,
    parameter int unsigned T_TIMEOUT = DEF_T_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    adc_interface_par12_if.slave bus
);

    localparam cnt_t CONV_LAST  = last_cnt(T_CONVST);
    localparam cnt_t GRACE_LAST = last_cnt(T_CONVST + BUSY_GRACE);
    localparam cnt_t RD_LAST    = last_cnt(T_RD);
    localparam cnt_t TO_LAST    = last_cnt(T_TIMEOUT);

    cmd_t        cmd_q, cmd_d;
    state_t      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        busy_seen_q, busy_seen_d;
    logic        rdy_q, rdy_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [1:0]  ad_q, ad_d;
    logic        convst_q, convst_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic [11:0] sample_q, sample_d;

    logic        busy_s;
    logic        unused_cmd_bits;

    assign unused_cmd_bits = ^{bus.op[3:2], bus.addr[7:2]};

    sync_2ff u_busy_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.BUSY),
        .q   (busy_s)
    );

    // Host command register: strobes only live for the cycle after cs,
    // soft reset masks a simultaneous start.
    always_comb begin
        cmd_d.start = bus.cs & bus.op[OP_CONV] & ~bus.op[OP_RST];
        cmd_d.srst  = bus.cs & bus.op[OP_RST];
        cmd_d.chan  = bus.cs ? bus.addr[1:0] : cmd_q.chan;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + cnt_t'(1);
        busy_seen_d = busy_seen_q;
        rdy_d       = rdy_q;
        valid_d     = 1'b0;
        err_d       = err_q;
        ad_d        = ad_q;
        convst_d    = convst_q;
        cs_n_d      = cs_n_q;
        rd_n_d      = rd_n_q;
        sample_d    = sample_q;

        if (cmd_q.srst) begin
            state_d     = S_RESET;
            cnt_d       = '0;
            busy_seen_d = 1'b0;
            rdy_d       = 1'b0;
            err_d       = 1'b0;
            ad_d        = '0;
            convst_d    = 1'b1;
            cs_n_d      = 1'b1;
            rd_n_d      = 1'b1;
            sample_d    = '0;
        end else begin
            case (state_q)
                S_RESET: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    rdy_d   = 1'b1;
                end

                S_IDLE: begin
                    cnt_d = '0;
                    if (cmd_q.start) begin
                        state_d = S_SETUP;
                        rdy_d   = 1'b0;
                        err_d   = 1'b0;
                        ad_d    = cmd_q.chan;
                    end
                end

                S_SETUP: begin
                    state_d  = S_CONV;
                    cnt_d    = '0;
                    convst_d = 1'b0;
                end

                S_CONV: begin
                    if (cnt_q == CONV_LAST) begin
                        state_d     = S_WAIT;
                        cnt_d       = '0;
                        convst_d    = 1'b1;
                        busy_seen_d = 1'b0;
                    end
                end

                S_WAIT: begin
                    if (busy_s) begin
                        busy_seen_d = 1'b1;
                    end
                    // Normal end: BUSY fell after being seen high.
                    // No-BUSY end: grace period expired with BUSY never high.
                    if ((busy_seen_q && !busy_s) ||
                        (!busy_seen_q && !busy_s && cnt_q == GRACE_LAST)) begin
                        state_d = S_READ;
                        cnt_d   = '0;
                        cs_n_d  = 1'b0;
                        rd_n_d  = 1'b0;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        rdy_d   = 1'b1;
                    end
                end

                S_READ: begin
                    if (cnt_q == RD_LAST) begin
                        state_d  = S_IDLE;
                        cnt_d    = '0;
                        sample_d = bus.DB;
                        cs_n_d   = 1'b1;
                        rd_n_d   = 1'b1;
                        valid_d  = 1'b1;
                        rdy_d    = 1'b1;
                    end
                end

                default: begin
                    state_d = S_RESET;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q       <= '0;
            state_q     <= S_RESET;
            cnt_q       <= '0;
            busy_seen_q <= 1'b0;
            rdy_q       <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            ad_q        <= '0;
            convst_q    <= 1'b1;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            sample_q    <= '0;
        end else begin
            cmd_q       <= cmd_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_seen_q <= busy_seen_d;
            rdy_q       <= rdy_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            ad_q        <= ad_d;
            convst_q    <= convst_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            sample_q    <= sample_d;
        end
    end

    assign bus.rdy      = rdy_q;
    assign bus.valid    = valid_q;
    assign bus.err      = err_q;
    assign bus.data_out = {4'b0000, sample_q};
    assign bus.AD       = ad_q;
    assign bus.CONVST   = convst_q;
    assign bus.CS       = cs_n_q;
    assign bus.RD       = rd_n_q;

endmodule

// File: tb/tb_adc_interface_par12.sv
// Bench for adc_interface_par12: a behavioural ADC model drives BUSY/DB,
// stimulus pushes expected samples into a scoreboard queue, and a monitor
// pops and compares on every valid pulse.
module tb_adc_interface_par12;

    localparam int unsigned TB_T_CONVST  = 2;
    localparam int unsigned TB_T_RD      = 3;
    localparam int unsigned TB_T_TIMEOUT = 200;
    // Start-to-valid latency when the ADC never raises BUSY
    localparam int NO_BUSY_LAT = 1 + 1 + TB_T_CONVST + (TB_T_CONVST + 4) + TB_T_RD + 1;

    logic clk;
    logic rst;

    adc_interface_par12_if bus ();

    adc_interface_par12 #(
        .T_CONVST  (TB_T_CONVST),
        .T_RD      (TB_T_RD),
        .T_TIMEOUT (TB_T_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] data;
        int          lat;
        int          issue;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          convst_falls = 0;
    logic [11:0] adc_db = '0;
    int          busy_len = 0;
    bit          busy_forever = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC model: BUSY rises half a cycle after CONVST falls and stays high
    // busy_len cycles (0 = never, busy_forever = until released). DB carries
    // the sample only on the T_RD-th cycle of RD low, its inverse otherwise.
    initial begin : adc_model
        int   busy_left;
        int   rd_run;
        logic convst_prev;
        busy_left   = 0;
        rd_run      = 0;
        convst_prev = 1'b1;
        bus.BUSY    = 1'b0;
        bus.DB      = '0;
        forever begin
            @(negedge clk);
            if (bus.CONVST === 1'b0 && convst_prev === 1'b1) begin
                if (busy_forever || busy_len > 0) begin
                    bus.BUSY  = 1'b1;
                    busy_left = busy_len;
                end
            end else if (bus.BUSY && !busy_forever) begin
                if (busy_left <= 1) bus.BUSY = 1'b0;
                else busy_left--;
            end
            convst_prev = bus.CONVST;
            if (bus.RD === 1'b0) rd_run++;
            else rd_run = 0;
            bus.DB = (rd_run == TB_T_RD) ? adc_db : ~adc_db;
        end
    end

    initial begin : monitor
        int   low_run;
        exp_t e;
        low_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                low_run = 0;
            end else begin
                if (bus.CONVST === 1'b0) begin
                    if (low_run == 0) convst_falls++;
                    low_run++;
                end else if (low_run != 0) begin
                    chk("convst_low_width", 32'(low_run), TB_T_CONVST);
                    low_run = 0;
                end
                if (bus.CS === 1'b0 || bus.RD === 1'b0)
                    chk("cs_rd_together", 32'(bus.CS), 32'(bus.RD));
                if (bus.valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got valid with data_out %0h, expected no valid", bus.data_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data_out", 32'(bus.data_out), 32'(e.data));
                        chk("ad_channel", 32'(bus.AD), 32'(e.ch));
                        chk("rdy_at_valid", 32'(bus.rdy), 1);
                        chk("err_at_valid", 32'(bus.err), 0);
                        if (e.lat >= 0) chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                    end
                end
            end
        end
    end

    task automatic do_cmd(input logic [3:0] op, input logic [7:0] addr, output int issue);
        @(negedge clk);
        bus.cs   = 1'b1;
        bus.op   = op;
        bus.addr = addr;
        issue    = cyc;
        @(negedge clk);
        bus.cs   = 1'b0;
        bus.op   = '0;
        bus.addr = '0;
    endtask

    task automatic start_conv(input logic [1:0] ch, input logic [11:0] db, input int blen, input bit push);
        int   issue;
        exp_t e;
        adc_db   = db;
        busy_len = blen;
        do_cmd({2'($urandom), 2'b10}, {6'($urandom), ch}, issue);
        if (push) begin
            e.ch    = ch;
            e.data  = {4'h0, db};
            e.lat   = (blen == 0 && !busy_forever) ? NO_BUSY_LAT : -1;
            e.issue = issue;
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk("rdy_drop_on_start", 32'(bus.rdy), 0);
    endtask

    task automatic wait_rdy(input string name);
        for (int i = 0; i < 500 && bus.rdy !== 1'b1; i++) @(negedge clk);
        chk(name, 32'(bus.rdy), 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drain", 32'(exp_q.size()), 0);
    endtask

    task automatic wait_convst_rise(output int rise_cyc);
        for (int i = 0; i < 50 && bus.CONVST !== 1'b0; i++) @(negedge clk);
        chk("convst_fall", 32'(bus.CONVST), 0);
        for (int i = 0; i < 50 && bus.CONVST !== 1'b1; i++) @(negedge clk);
        chk("convst_rise", 32'(bus.CONVST), 1);
        rise_cyc = cyc;
    endtask

    initial begin : stim
        int          r;
        int          falls0;
        int          issue;
        logic [11:0] b2b_db [4];
        b2b_db = '{12'h000, 12'hFFF, 12'h800, 12'h001};

        rst      = 1'b1;
        bus.cs   = 1'b0;
        bus.op   = '0;
        bus.addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_convst", 32'(bus.CONVST), 1);
        chk("rst_cs", 32'(bus.CS), 1);
        chk("rst_rd", 32'(bus.RD), 1);
        chk("rst_ad", 32'(bus.AD), 0);
        chk("rst_rdy", 32'(bus.rdy), 0);
        chk("rst_valid", 32'(bus.valid), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_data_out", 32'(bus.data_out), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rdy_in_s_reset", 32'(bus.rdy), 0);
        @(negedge clk);
        chk("rdy_in_s_idle", 32'(bus.rdy), 1);

        // Basic conversion on channel 2
        start_conv(2'd2, 12'hA5C, 20, 1'b1);
        wait_drain();

        // BUSY stuck high: timeout 200 cycles after CONVST rise
        busy_forever = 1'b1;
        start_conv(2'd1, 12'h123, 0, 1'b0);
        wait_convst_rise(r);
        for (int i = 0; i < 400 && bus.err !== 1'b1; i++) @(negedge clk);
        chk("err_timeout", 32'(bus.err), 1);
        chk("timeout_cycles", 32'(cyc - r), TB_T_TIMEOUT);
        chk("rdy_after_timeout", 32'(bus.rdy), 1);
        busy_forever = 1'b0;
        repeat (5) @(negedge clk);
        chk("err_sticky", 32'(bus.err), 1);

        // op = 0011: soft reset wins, no conversion
        falls0 = convst_falls;
        do_cmd(4'b0011, 8'h01, issue);
        @(negedge clk);
        chk("soft_rst_rdy_low", 32'(bus.rdy), 0);
        chk("soft_rst_err_clr", 32'(bus.err), 0);
        chk("soft_rst_data_clr", 32'(bus.data_out), 0);
        @(negedge clk);
        chk("soft_rst_rdy_back", 32'(bus.rdy), 1);
        repeat (10) @(negedge clk);
        chk("soft_rst_no_convst", 32'(convst_falls - falls0), 0);

        // Second start during S_WAIT is dropped
        falls0 = convst_falls;
        start_conv(2'd3, 12'h3C5, 30, 1'b1);
        wait_convst_rise(r);
        do_cmd(4'b0010, 8'h00, issue);
        wait_drain();
        repeat (40) @(negedge clk);
        chk("ignored_start_one_convst", 32'(convst_falls - falls0), 1);

        // rst on the second RD-low cycle aborts the read
        start_conv(2'd1, 12'h5A5, 10, 1'b0);
        for (int i = 0; i < 200 && bus.RD !== 1'b0; i++) @(negedge clk);
        chk("rd_low_seen", 32'(bus.RD), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_cs_high", 32'(bus.CS), 1);
        chk("abort_rd_high", 32'(bus.RD), 1);
        chk("abort_data_out", 32'(bus.data_out), 0);
        chk("abort_valid", 32'(bus.valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_rdy("rdy_after_abort");
        repeat (20) @(negedge clk);
        chk("data_out_after_abort", 32'(bus.data_out), 0);

        // Back-to-back on channels 0..3
        for (int ch = 0; ch < 4; ch++) begin
            wait_rdy("rdy_b2b");
            start_conv(2'(ch), b2b_db[ch], ch * 3, 1'b1);
        end
        wait_drain();

        // Randomised conversions
        for (int n = 0; n < 20; n++) begin
            int bl;
            bl = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            wait_rdy("rdy_rand");
            start_conv(2'($urandom_range(0, 3)), 12'($urandom), bl, 1'b1);
        end
        wait_drain();
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adc_interface_par12.md
ADC_INTERFACE_PAR12 -- requirements
Module: adc_interface_par12

Interface
REQ-001 Parameter T_CONVST, default 2: CONVST low-pulse width, clk cycles.
REQ-002 Parameter T_RD, default 3: RD low width, clk cycles; DB sampled on last cycle.
REQ-003 Parameter T_TIMEOUT, default 200: max cycles from CONVST rise to BUSY fall.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 cs  input  1  host command strobe, one cycle.
REQ-008 op  input  4  op[0] soft reset, op[1] start conversion, op[3:2] ignored.
REQ-009 addr  input  8  addr[1:0] ADC channel; addr[7:2] ignored.
REQ-010 rdy  output  1  high when idle and able to accept a conversion.
REQ-011 data_out  output  16  {4'b0, last sample[11:0]}.
REQ-012 valid  output  1  one-cycle pulse when data_out updates.
REQ-013 err  output  1  sticky BUSY-timeout flag, cleared by reset or next accepted start.
REQ-014 AD  output  2  channel select to ADC.
REQ-015 CONVST  output  1  conversion start, active low.
REQ-016 BUSY  input  1  ADC busy, active high, asynchronous to clk.
REQ-017 CS  output  1  ADC chip select, active low.
REQ-018 RD  output  1  ADC read strobe, active low.
REQ-019 DB  input  12  ADC parallel data bus.

Function
REQ-020 When cs=1, op/addr SHALL be registered; start/soft-reset take effect the following cycle; when cs=0 the registered start/soft-reset SHALL be 0.
REQ-021 If op[0] and op[1] are set together, soft reset SHALL win.
REQ-022 Soft reset SHALL act identically to rst but synchronously.
REQ-023 States: S_RESET, S_IDLE, S_SETUP, S_CONV, S_WAIT, S_READ.
REQ-024 S_RESET -> S_IDLE one cycle after reset deasserts; rdy=1 on entry to S_IDLE.
REQ-025 S_IDLE, start seen: rdy<=0, err<=0, AD<=channel, -> S_SETUP; otherwise hold.
REQ-026 S_SETUP lasts 1 cycle, then CONVST<=0, -> S_CONV.
REQ-027 S_CONV: CONVST held low exactly T_CONVST cycles, then CONVST<=1, -> S_WAIT.
REQ-028 BUSY SHALL pass through a 2-flop synchronizer; S_WAIT exits on synchronized BUSY=0 observed after it was seen 1, or after T_CONVST+4 cycles in S_WAIT with BUSY never seen high.
REQ-029 S_WAIT exceeding T_TIMEOUT cycles: err<=1, rdy<=1, no valid, -> S_IDLE.
REQ-030 S_READ: CS and RD low together for T_RD cycles; DB captured on last low cycle; then CS, RD <=1, data_out updated, valid=1 for one cycle, rdy<=1, -> S_IDLE.
REQ-031 Start commands outside S_IDLE SHALL be ignored, not queued.
REQ-032 Cycle counter SHALL be 8 bits, cleared on every state entry; parameters SHALL not exceed 255.
REQ-033 Start-to-valid latency SHALL be 1+1+T_CONVST+(wait)+T_RD+1 cycles.

Reset
REQ-034 rst or soft reset, any state: CONVST=1, CS=1, RD=1, AD=0, rdy=0, valid=0, err=0, data_out=0, state S_RESET.
REQ-035 Reset mid-read SHALL deassert CS/RD immediately (asynchronously for rst) and discard the sample.

Structure
REQ-036 Shared package SHALL hold state encodings, op bit indices (OP_RST=0, OP_CONV=1), and default parameter constants.
REQ-037 One sub-module, sync_2ff, SHALL synchronize BUSY.

Verification
REQ-038 rst pulse, then cs=1, op=4'b0010, addr=8'h02, BUSY high 20 cycles, DB=12'hA5C -> AD=2, CONVST low 2 cycles, valid pulse, data_out=16'h0A5C, rdy=1.
REQ-039 BUSY held high forever after start -> err=1 at 200 cycles after CONVST rise, rdy=1, valid never asserted.
REQ-040 cs=1, op=4'b0011 -> soft reset only; no CONVST pulse; rdy returns to 1 two cycles later.
REQ-041 Second start issued during S_WAIT -> ignored; exactly one valid pulse.
REQ-042 rst asserted on second RD-low cycle -> CS=RD=1 same cycle, data_out=0, no valid.
REQ-043 Back-to-back starts on channels 0..3 with DB=12'h000, 12'hFFF, 12'h800, 12'h001 -> four valid pulses, AD and data_out match per channel.
